dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_array.sv | 37 +++
 rtl/dmem_responder.sv | 136 +++++++++++++
 tb/tb_dmem_responder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, wait-counter width
// and default memory depth.
package dmem_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWait = 2'd1,
      StResp = 2'd2
   } dmem_state_e;

   localparam int unsigned CntW              = 4;
   localparam int unsigned DefaultDepthWords = 256;

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port RAM, DEPTH_WORDS x 32, with per-byte-lane write enables.
// Contents are not reset; read data is registered.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = DefaultDepthWords,
   parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic             clk,
   input  logic             en,
   input  logic             we,
   input  logic [3:0]       be,
   input  logic [IDX_W-1:0] idx,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);

   logic [31:0] mem [DEPTH_WORDS];
   logic [31:0] rdata_q;

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < 4; i++) begin
               if (be[i]) begin
                  mem[idx][8*i +: 8] <= wdata[8*i +: 8];
               end
            end
         end else begin
            rdata_q <= mem[idx];
         end
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, waits WAIT_CYCLES, then presents a
// response held until handshaken. Misaligned or out-of-range accesses report an error.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DEPTH_WORDS = DefaultDepthWords,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [3:0]        req_be,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err
);

   localparam int unsigned    IdxW    = $clog2(DEPTH_WORDS);
   localparam logic [CntW-1:0] CntLoad = (WAIT_CYCLES == 0) ? '0 : CntW'(WAIT_CYCLES - 1);

   dmem_state_e       state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [3:0]        be_q;
   logic              we_q;
   logic              err_q;
   logic              init_q;
   logic              accept;
   logic              enter_resp;

   // With zero wait states the memory is accessed on the accept edge itself, so the
   // request fields must come straight from the inputs while idle.
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [3:0]        sel_be;
   logic              sel_we;
   logic              addr_err;
   logic [DATA_W-1:0] mem_rdata;

   assign sel_addr  = (state_q == StIdle) ? req_addr  : addr_q;
   assign sel_wdata = (state_q == StIdle) ? req_wdata : wdata_q;
   assign sel_be    = (state_q == StIdle) ? req_be    : be_q;
   assign sel_we    = (state_q == StIdle) ? req_we    : we_q;

   assign addr_err = (sel_addr[1:0] != 2'b00) ||
                     ({2'b00, sel_addr[ADDR_W-1:2]} >= ADDR_W'(DEPTH_WORDS));

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      accept     = 1'b0;
      enter_resp = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req_valid && req_ready) begin
               accept = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  state_d    = StResp;
                  enter_resp = 1'b1;
               end else begin
                  state_d = StWait;
                  cnt_d   = CntLoad;
               end
            end
         end
         StWait: begin
            if (cnt_q == '0) begin
               state_d    = StResp;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         StResp: begin
            if (resp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         init_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         init_q  <= 1'b1;
         if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
            we_q    <= req_we;
         end
         if (enter_resp) begin
            err_q <= addr_err;
         end
      end
   end

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IdxW)
   ) u_array (
      .clk   (clk),
      .en    (enter_resp && !addr_err),
      .we    (sel_we),
      .be    (sel_be),
      .idx   (sel_addr[IdxW+1:2]),
      .wdata (sel_wdata),
      .rdata (mem_rdata)
   );

   // Ready is held low until the first edge after reset release.
   assign req_ready  = (state_q == StIdle) && init_q;
   assign resp_valid = (state_q == StResp);
   assign resp_err   = resp_valid && err_q;
   assign resp_rdata = (resp_valid && !err_q && !we_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus randomized traffic checked against a
// word-level memory model; a second instance with zero wait states checks streaming.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        reset;

   logic        req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
   logic [31:0] req_addr, req_wdata, resp_rdata;
   logic [3:0]  req_be;

   logic        req_valid_z, req_ready_z, req_we_z, resp_valid_z, resp_ready_z, resp_err_z;
   logic [31:0] req_addr_z, req_wdata_z, resp_rdata_z;
   logic [3:0]  req_be_z;

   int checks = 0;
   int errors = 0;

   logic [31:0] mdl [int unsigned];

   always #5 clk = ~clk;

   dmem_responder #(
      .DATA_W (32), .ADDR_W (32), .DEPTH_WORDS (256), .WAIT_CYCLES (2)
   ) u_dut (
      .clk (clk), .reset (reset),
      .req_valid (req_valid), .req_ready (req_ready), .req_we (req_we),
      .req_addr (req_addr), .req_wdata (req_wdata), .req_be (req_be),
      .resp_valid (resp_valid), .resp_ready (resp_ready),
      .resp_rdata (resp_rdata), .resp_err (resp_err)
   );

   dmem_responder #(
      .DATA_W (32), .ADDR_W (32), .DEPTH_WORDS (256), .WAIT_CYCLES (0)
   ) u_dut_z (
      .clk (clk), .reset (reset),
      .req_valid (req_valid_z), .req_ready (req_ready_z), .req_we (req_we_z),
      .req_addr (req_addr_z), .req_wdata (req_wdata_z), .req_be (req_be_z),
      .resp_valid (resp_valid_z), .resp_ready (resp_ready_z),
      .resp_rdata (resp_rdata_z), .resp_err (resp_err_z)
   );

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
      return r;
   endfunction

   function automatic logic is_err(input logic [31:0] addr);
      return (addr % 4 != 0) || (addr / 4 >= 256);
   endfunction

   // Model update for a store; errored stores leave memory untouched.
   task automatic model_store(input logic [31:0] addr, input logic [31:0] wd,
                              input logic [3:0] be);
      logic [31:0] old;
      if (is_err(addr)) return;
      old = mdl.exists(addr / 4) ? mdl[addr / 4] : 32'h0;
      mdl[addr / 4] = merge(old, wd, be);
   endtask

   task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, output logic [31:0] rdata,
                         output logic err, output int lat);
      int n = 0;
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
      while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL accept_timeout: req_ready=%b required 1", req_ready);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
      lat = 1;
      while (!resp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
      rdata = resp_rdata;
      err   = resp_err;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #3;
      checks += 4;
      if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b exp 0", req_ready); end
      if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b exp 0", resp_valid); end
      if (resp_err !== 1'b0) begin errors++; $display("FAIL rst_resp_err: got %b exp 0", resp_err); end
      if (resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_resp_rdata: got %h exp 0", resp_rdata); end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_hold_ready: got %b exp 0", req_ready); end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      checks += 2;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b exp 1", req_ready); end
      if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_release_valid: got %b exp 0", resp_valid); end
   endtask

   task automatic test_store_load();
      logic [31:0] rd; logic er; int lat;
      do_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, rd, er, lat);
      model_store(32'h10, 32'hDEADBEEF, 4'b1111);
      checks += 3;
      if (lat != 3) begin errors++; $display("FAIL store_latency: got %0d exp 3", lat); end
      if (er !== 1'b0) begin errors++; $display("FAIL store_err: got %b exp 0", er); end
      if (rd !== 32'h0) begin errors++; $display("FAIL store_rdata: got %h exp 0", rd); end
      do_txn(1'b1, 32'h10, 32'h000000AA, 4'b0001, rd, er, lat);
      model_store(32'h10, 32'h000000AA, 4'b0001);
      do_txn(1'b1, 32'h14, 32'h01234567, 4'b0000, rd, er, lat);
      do_txn(1'b0, 32'h10, 32'h0, 4'b0, rd, er, lat);
      checks += 3;
      if (rd !== 32'hDEADBEAA) begin errors++; $display("FAIL merged_load: got %h exp deadbeaa", rd); end
      if (er !== 1'b0) begin errors++; $display("FAIL merged_load_err: got %b exp 0", er); end
      if (lat != 3) begin errors++; $display("FAIL load_latency: got %0d exp 3", lat); end
   endtask

   task automatic test_errors();
      logic [31:0] rd; logic er; int lat;
      do_txn(1'b0, 32'h13, 32'h0, 4'b0, rd, er, lat);
      checks += 2;
      if (er !== 1'b1) begin errors++; $display("FAIL misalign_err: got %b exp 1", er); end
      if (rd !== 32'h0) begin errors++; $display("FAIL misalign_rdata: got %h exp 0", rd); end
      do_txn(1'b0, 32'h400, 32'h0, 4'b0, rd, er, lat);
      checks += 2;
      if (er !== 1'b1) begin errors++; $display("FAIL oor_err: got %b exp 1", er); end
      if (rd !== 32'h0) begin errors++; $display("FAIL oor_rdata: got %h exp 0", rd); end
      // A misaligned store must not touch the word it lands in.
      do_txn(1'b1, 32'h11, 32'h77777777, 4'b1111, rd, er, lat);
      checks++;
      if (er !== 1'b1) begin errors++; $display("FAIL misalign_store_err: got %b exp 1", er); end
      do_txn(1'b0, 32'h10, 32'h0, 4'b0, rd, er, lat);
      checks++;
      if (rd !== mdl[4]) begin errors++; $display("FAIL misalign_no_write: got %h exp %h", rd, mdl[4]); end
   endtask

   task automatic test_hold();
      int n = 0;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_wdata = '0; req_be = '0;
      while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      req_valid = 1'b0; req_addr = 32'h13;
      n = 0;
      while (!resp_valid && n < 40) begin @(posedge clk); #1; n++; end
      for (int c = 0; c < 5; c++) begin
         checks += 4;
         if (resp_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d]: got %b exp 1", c, resp_valid); end
         if (resp_rdata !== mdl[4]) begin errors++; $display("FAIL hold_rdata[%0d]: got %h exp %h", c, resp_rdata, mdl[4]); end
         if (resp_err !== 1'b0) begin errors++; $display("FAIL hold_err[%0d]: got %b exp 0", c, resp_err); end
         if (req_ready !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d]: got %b exp 0", c, req_ready); end
         @(posedge clk); #1;
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      checks += 2;
      if (resp_valid !== 1'b0) begin errors++; $display("FAIL hold_release_valid: got %b exp 0", resp_valid); end
      if (req_ready !== 1'b1) begin errors++; $display("FAIL hold_release_ready: got %b exp 1", req_ready); end
   endtask

   task automatic test_reset_mid_wait();
      logic [31:0] rd; logic er; int lat; int n = 0;
      do_txn(1'b1, 32'h20, 32'h12345678, 4'b1111, rd, er, lat);
      model_store(32'h20, 32'h12345678, 4'b1111);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h5555AAAA; req_be = 4'hF;
      while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      req_valid = 1'b0;
      #2 reset = 1'b0;
      #1;
      checks += 4;
      if (resp_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b exp 0", resp_valid); end
      if (req_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b exp 0", req_ready); end
      if (resp_err !== 1'b0) begin errors++; $display("FAIL midrst_err: got %b exp 0", resp_err); end
      if (resp_rdata !== 32'h0) begin errors++; $display("FAIL midrst_rdata: got %h exp 0", resp_rdata); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      do_txn(1'b0, 32'h20, 32'h0, 4'b0, rd, er, lat);
      checks += 2;
      if (rd !== 32'h12345678) begin errors++; $display("FAIL midrst_no_commit: got %h exp 12345678", rd); end
      if (er !== 1'b0) begin errors++; $display("FAIL midrst_load_err: got %b exp 0", er); end
   endtask

   task automatic test_random();
      logic [31:0] rd, addr, wd, exp_rd; logic er, we, exp_er; logic [3:0] be; int lat;
      for (int i = 0; i < 16; i++) begin
         wd = $urandom;
         do_txn(1'b1, 32'(i * 4), wd, 4'hF, rd, er, lat);
         model_store(32'(i * 4), wd, 4'hF);
      end
      for (int t = 0; t < 40; t++) begin
         int kind = $urandom_range(0, 9);
         if (kind <= 5)      addr = 32'($urandom_range(0, 15) * 4);
         else if (kind <= 7) addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
         else                addr = 32'($urandom_range(256, 32'h3FFF_FFFF)) << 2;
         we = 1'($urandom); wd = $urandom; be = 4'($urandom);
         exp_er = is_err(addr);
         exp_rd = (exp_er || we) ? 32'h0 : mdl[addr / 4];
         do_txn(we, addr, wd, be, rd, er, lat);
         if (we) model_store(addr, wd, be);
         checks += 3;
         if (er !== exp_er) begin errors++; $display("FAIL rand_err[%0d] addr=%h: got %b exp %b", t, addr, er, exp_er); end
         if (rd !== exp_rd) begin errors++; $display("FAIL rand_rdata[%0d] addr=%h: got %h exp %h", t, addr, rd, exp_rd); end
         if (lat != 3) begin errors++; $display("FAIL rand_latency[%0d]: got %0d exp 3", t, lat); end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] bmem [4];
      logic [31:0] exp_rd;
      resp_ready_z = 1'b1;
      for (int i = 0; i < 8; i++) begin
         req_valid_z = 1'b1;
         if (i < 4) begin
            req_we_z = 1'b1; req_addr_z = 32'(i * 4); req_wdata_z = $urandom; req_be_z = 4'hF;
            bmem[i] = req_wdata_z;
            exp_rd = 32'h0;
         end else begin
            req_we_z = 1'b0; req_addr_z = 32'((7 - i) * 4); req_wdata_z = $urandom; req_be_z = '0;
            exp_rd = bmem[7 - i];
         end
         checks++;
         if (req_ready_z !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b exp 1", i, req_ready_z); end
         @(posedge clk); #1;
         checks += 4;
         if (resp_valid_z !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b exp 1", i, resp_valid_z); end
         if (resp_err_z !== 1'b0) begin errors++; $display("FAIL b2b_err[%0d]: got %b exp 0", i, resp_err_z); end
         if (resp_rdata_z !== exp_rd) begin errors++; $display("FAIL b2b_rdata[%0d]: got %h exp %h", i, resp_rdata_z, exp_rd); end
         if (req_ready_z !== 1'b0) begin errors++; $display("FAIL b2b_busy[%0d]: got %b exp 0", i, req_ready_z); end
         if (i == 7) req_valid_z = 1'b0;
         @(posedge clk); #1;
         checks++;
         if (resp_valid_z !== 1'b0) begin errors++; $display("FAIL b2b_bubble[%0d]: got %b exp 0", i, resp_valid_z); end
      end
   endtask

   initial begin
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
      resp_ready = 1'b0;
      req_valid_z = 1'b0; req_we_z = 1'b0; req_addr_z = '0; req_wdata_z = '0; req_be_z = '0;
      resp_ready_z = 1'b0;
      test_reset();
      test_store_load();
      test_errors();
      test_hold();
      test_reset_mid_wait();
      test_random();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
